// File: rtl/priority_encoder8x3_hs_if.sv
// priority_encoder8x3_hs_if: request/handshake bundle (enable, req, ready in; valid, code, pending, drop_cnt out) for priority_encoder8x3_hs
interface priority_encoder8x3_hs_if #(parameter int CNT_W = 8);
  logic enable, ready, valid;
  logic [7:0] req, pending;
  logic [2:0] code;
  logic [CNT_W-1:0] drop_cnt;
  modport master(output enable, req, ready, input valid, code, pending, drop_cnt);
  modport slave(input enable, req, ready, output valid, code, pending, drop_cnt);
endinterface

// File: rtl/priority_encoder8x3_hs.sv
// priority_encoder8x3_hs: latched 8-to-3 priority encoder on valid/ready (clk, rst_n sync active-low, bus: enable/req/ready in, valid/code/pending/drop_cnt out); define PRIO_ENC_ROUND_ROBIN_EN for rotating priority
module priority_encoder8x3_hs #(
  parameter int PRIO_HIGH = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  priority_encoder8x3_hs_if.slave bus
);
  typedef enum logic {IDLE, PRESENT} state_t;
  localparam logic [2:0] PTR_RST = (PRIO_HIGH != 0) ? 3'd7 : 3'd0;
  state_t state, state_n;
  logic [7:0] pending, cap, clr, kept, nxt;
  logic [2:0] code, code_n, ptr, ptr_n, win, idx;
  logic [CNT_W-1:0] drop_cnt;
  logic acc, drop;
  assign cap = bus.req & {8{bus.enable}};
  assign acc = (state == PRESENT) & bus.ready;
  assign clr = acc ? (8'b1 << code) : 8'h0;
  assign kept = pending & ~clr;
  assign nxt = kept | cap;
  assign drop = |(cap & kept);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
  assign ptr_n = acc ? ((PRIO_HIGH != 0) ? code - 3'd1 : code + 3'd1) : ptr;
  always_ff @(posedge clk)
    ptr <= !rst_n ? PTR_RST : ptr_n;
`else
  assign ptr = PTR_RST;
  assign ptr_n = ptr;
`endif
  always_comb begin
    win = ptr_n;
    idx = ptr_n;
    for (int j = 7; j >= 0; j--) begin
      idx = (PRIO_HIGH != 0) ? ptr_n - 3'(j) : ptr_n + 3'(j);
      win = nxt[idx] ? idx : win;
    end
  end
  always_comb begin
    state_n = state;
    code_n = code;
    if (state == IDLE || bus.ready) begin
      state_n = (|nxt) ? PRESENT : IDLE;
      code_n = (|nxt) ? win : code;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      code <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      pending <= nxt;
      code <= code_n;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  assign bus.valid = (state == PRESENT);
  assign bus.code = code;
  assign bus.pending = pending;
  assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_priority_encoder8x3_hs.sv
// tb_priority_encoder8x3_hs: directed plus random checks of two encoder instances against a queue-free behavioural model
module tb_priority_encoder8x3_hs;
  logic clk = 0, rst_n = 0, enable = 1, ready = 0;
  logic [7:0] req = 8'hff;
  int checks = 0, errors = 0;
  logic [7:0] m_pend[2];
  logic [2:0] m_code[2], m_ptr[2];
  logic m_valid[2];
  int m_cnt[2];
  int cnt0_exp[4] = '{1, 2, 3, 3};
  int cnt1_exp[4] = '{1, 2, 3, 4};
  always #5 clk = ~clk;
  priority_encoder8x3_hs_if #(.CNT_W(2)) b0();
  priority_encoder8x3_hs_if #(.CNT_W(8)) b1();
  assign b0.enable = enable;
  assign b0.req = req;
  assign b0.ready = ready;
  assign b1.enable = enable;
  assign b1.req = req;
  assign b1.ready = ready;
  priority_encoder8x3_hs #(.PRIO_HIGH(1), .CNT_W(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  priority_encoder8x3_hs #(.PRIO_HIGH(0), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  function automatic bit rr_on();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction
  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model(int d);
    bit hi = (d == 0);
    int maxc = (d == 0) ? 3 : 255;
    int k, p, idx;
    logic [7:0] cap, clr, kept, nxt;
    bit acc;
    if (!rst_n) begin
      m_pend[d] = 0;
      m_valid[d] = 0;
      m_code[d] = 0;
      m_cnt[d] = 0;
      m_ptr[d] = hi ? 3'd7 : 3'd0;
      return;
    end
    k = int'(m_code[d]);
    cap = enable ? req : 8'h0;
    acc = m_valid[d] && ready;
    clr = acc ? 8'(1 << k) : 8'h0;
    kept = m_pend[d] & ~clr;
    nxt = kept | cap;
    if ((cap & kept) != 0 && m_cnt[d] < maxc) m_cnt[d]++;
    if (acc && rr_on()) m_ptr[d] = hi ? 3'((k + 7) % 8) : 3'((k + 1) % 8);
    if (!m_valid[d] || acc) begin
      m_valid[d] = (nxt != 0);
      p = int'(m_ptr[d]);
      for (int j = 0; j < 8; j++) begin
        idx = hi ? (p - j + 8) % 8 : (p + j) % 8;
        if (nxt[idx]) begin
          m_code[d] = 3'(idx);
          break;
        end
      end
    end
    m_pend[d] = nxt;
  endtask
  task automatic step();
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check("valid0", b0.valid, m_valid[0]);
    check("code0", b0.code, m_code[0]);
    check("pending0", b0.pending, m_pend[0]);
    check("drop_cnt0", b0.drop_cnt, m_cnt[0]);
    check("valid1", b1.valid, m_valid[1]);
    check("code1", b1.code, m_code[1]);
    check("pending1", b1.pending, m_pend[1]);
    check("drop_cnt1", b1.drop_cnt, m_cnt[1]);
  endtask
  initial begin
    step();
    step();
    check("rst_pending", b0.pending, 0);
    check("rst_valid", b0.valid, 0);
    check("rst_drop", b0.drop_cnt, 0);
    rst_n = 1;
    req = 8'h20;
    step();
    check("single_valid", b0.valid, 1);
    check("single_code", b0.code, 5);
    req = 8'h00;
    step();
    step();
    check("hold_code", b0.code, 5);
    check("hold_valid", b0.valid, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    ready = 1;
    req = 8'h81;
    step();
    check("drain_hi_first", b0.code, 7);
    check("drain_lo_first", b1.code, 0);
    req = 8'h00;
    step();
    check("drain_hi_second", b0.code, 0);
    check("drain_lo_second", b1.code, 7);
    check("drain_valid", b0.valid, 1);
    step();
    check("drain_idle", b0.valid, 0);
    check("drain_empty", b0.pending, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    ready = 0;
    req = 8'h04;
    step();
    check("nopre_code", b0.code, 2);
    req = 8'h80;
    step();
    check("nopre_hold", b0.code, 2);
    check("nopre_pending", b0.pending, 8'h84);
    req = 8'h00;
    ready = 1;
    step();
    check("nopre_next", b0.code, 7);
    ready = 0;
    rst_n = 0;
    step();
    rst_n = 1;
    req = 8'h08;
    step();
    check("drop_none", b0.drop_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("drop_sat", b0.drop_cnt, cnt0_exp[i]);
      check("drop_wide", b1.drop_cnt, cnt1_exp[i]);
    end
    req = 8'h18;
    step();
    check("drop_one_bit", b1.drop_cnt, 5);
    step();
    check("drop_two_bits", b1.drop_cnt, 6);
    check("drop_held_sat", b0.drop_cnt, 3);
    rst_n = 0;
    req = 8'h00;
    step();
    rst_n = 1;
    req = 8'h10;
    step();
    check("coll_code", b0.code, 4);
    ready = 1;
    step();
    check("coll_repeat", b0.code, 4);
    check("coll_valid", b0.valid, 1);
    check("coll_nodrop", b0.drop_cnt, 0);
    enable = 0;
    req = 8'hff;
    ready = 0;
    step();
    check("gate_pending", b0.pending, 8'h10);
    ready = 1;
    step();
    check("gate_drained", b0.valid, 0);
    check("gate_empty", b0.pending, 0);
    enable = 1;
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      enable = ($urandom_range(0, 3) != 0);
      req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
